// File: rtl/shift_seq_arb.sv
// Two-requester round-robin arbiter in front of a 16-bit shifter that resolves
// one bit of the shift amount per cycle, giving a fixed five-cycle latency.
module shift_seq_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [1:0]  op0,
    input  logic [1:0]  op1,
    input  logic [15:0] in0,
    input  logic [15:0] in1,
    input  logic [3:0]  amt0,
    input  logic [3:0]  amt1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        busy,
    output logic        done,
    output logic        done_id,
    output logic [15:0] result
);

    typedef enum logic [2:0] {IDLE, S0, S1, S2, S3, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q;
    logic [3:0]  amt_q;
    logic [15:0] work_q, work_d;
    logic [15:0] result_q;
    logic        idx_q;
    logic        doneId_q;
    logic        last_q;
    logic        stepEn;
    logic [4:0]  stepDist;

    // Rotates come out of a doubled copy of the word; logical shifts zero-fill.
    function automatic logic [15:0] moveBits(input logic [15:0] v,
                                             input logic [1:0]  op,
                                             input logic [4:0]  n);
        logic [31:0] dbl;
        logic [31:0] tmp;
        dbl = {v, v};
        tmp = '0;
        case (op)
            2'b00: begin
                tmp = dbl << n;
                moveBits = tmp[31:16];
            end
            2'b01: moveBits = v << n;
            2'b10: begin
                tmp = dbl >> n;
                moveBits = tmp[15:0];
            end
            default: moveBits = v >> n;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        stepEn   = 1'b0;
        stepDist = 5'd1;
        case (state_q)
            IDLE: begin
                // On a conflict, the requester not served last wins.
                if (req0 && req1) begin
                    gnt0 = last_q;
                    gnt1 = ~last_q;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
                if (req0 || req1) state_d = S0;
            end
            S0: begin
                stepEn   = amt_q[0];
                stepDist = 5'd1;
                state_d  = S1;
            end
            S1: begin
                stepEn   = amt_q[1];
                stepDist = 5'd2;
                state_d  = S2;
            end
            S2: begin
                stepEn   = amt_q[2];
                stepDist = 5'd4;
                state_d  = S3;
            end
            S3: begin
                stepEn   = amt_q[3];
                stepDist = 5'd8;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        work_d = stepEn ? moveBits(work_q, op_q, stepDist) : work_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // The result register loads on the way into DONE so it is valid with the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= 2'b00;
            amt_q    <= 4'd0;
            work_q   <= 16'h0000;
            idx_q    <= 1'b0;
            last_q   <= 1'b1;
            result_q <= 16'h0000;
            doneId_q <= 1'b0;
        end else begin
            if (state_q == IDLE && (req0 || req1)) begin
                op_q   <= gnt1 ? op1  : op0;
                amt_q  <= gnt1 ? amt1 : amt0;
                work_q <= gnt1 ? in1  : in0;
                idx_q  <= gnt1;
                last_q <= gnt1;
            end else if (state_q inside {S0, S1, S2, S3}) begin
                work_q <= work_d;
            end
            if (state_q == S3) begin
                result_q <= work_d;
                doneId_q <= idx_q;
            end
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign done_id = doneId_q;
    assign result  = result_q;

endmodule
